// File: rtl/digit_loader_6_4b.sv
// rtl/digit_loader_6_4b.sv - six-slot BCD digit loader with range check and atomic commit
module digit_loader_6_4b #(
    parameter int NSLOT = 6,
    parameter int DW    = 4
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_valid,
    input  logic [DW-1:0] i_digit,
    output logic          o_ready,
    output logic [2:0]    o_ptr,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic [DW-1:0] o_out0,
    output logic [DW-1:0] o_out1,
    output logic [DW-1:0] o_out2,
    output logic [DW-1:0] o_out3,
    output logic [DW-1:0] o_out4,
    output logic [DW-1:0] o_out5
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    localparam logic [2:0] LAST_SLOT = 3'(NSLOT - 1);

    logic [1:0]    r_state;
    logic [2:0]    r_ptr;
    logic          r_done;
    logic          r_err;
    logic [DW-1:0] r_shadow [0:NSLOT-1];
    logic [DW-1:0] r_out    [0:NSLOT-1];

    logic w_xfer;
    logic w_legal;

    assign w_xfer = i_valid && (r_state == S_LOAD);

    // Hours-units limit depends on the hours-tens digit already staged.
    always_comb begin
        w_legal = 1'b0;
        case (r_ptr)
            3'd0:       w_legal = (i_digit <= 4'd2);
            3'd1:       w_legal = (r_shadow[0] == 4'd2) ? (i_digit <= 4'd3) : (i_digit <= 4'd9);
            3'd2, 3'd4: w_legal = (i_digit <= 4'd5);
            3'd3, 3'd5: w_legal = (i_digit <= 4'd9);
            default:    w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'd0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            for (int i = 0; i < NSLOT; i++) begin
                r_shadow[i] <= '0;
                r_out[i]    <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_LOAD;
                        r_ptr   <= 3'd0;
                        r_err   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // Restart wins over a same-cycle transfer; that digit is dropped.
                    if (i_start) begin
                        r_ptr <= 3'd0;
                    end else if (w_xfer) begin
                        if (w_legal) begin
                            r_shadow[r_ptr] <= i_digit;
                            if (r_ptr == LAST_SLOT) begin
                                r_state <= S_COMMIT;
                            end else begin
                                r_ptr <= r_ptr + 3'd1;
                            end
                        end else begin
                            r_err   <= 1'b1;
                            r_ptr   <= 3'd0;
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < NSLOT; i++) begin
                        r_out[i] <= r_shadow[i];
                    end
                    r_done  <= 1'b1;
                    r_ptr   <= 3'd0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ptr   <= 3'd0;
                end
            endcase
        end
    end

    assign o_ready = (r_state == S_LOAD);
    assign o_busy  = (r_state != S_IDLE);
    assign o_ptr   = r_ptr;
    assign o_done  = r_done;
    assign o_err   = r_err;
    assign o_out0  = r_out[0];
    assign o_out1  = r_out[1];
    assign o_out2  = r_out[2];
    assign o_out3  = r_out[3];
    assign o_out4  = r_out[4];
    assign o_out5  = r_out[5];

endmodule

// File: tb/tb_digit_loader_6_4b.sv
// tb/tb_digit_loader_6_4b.sv - directed self-checking bench for digit_loader_6_4b
module tb_digit_loader_6_4b;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic       i_valid = 1'b0;
    logic [3:0] i_digit = 4'd0;
    logic       o_ready, o_busy, o_done, o_err;
    logic [2:0] o_ptr;
    logic [3:0] o_out0, o_out1, o_out2, o_out3, o_out4, o_out5;
    logic [23:0] w_outs;

    int n_pass = 0;
    int n_total = 0;

    digit_loader_6_4b dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid),
        .i_digit(i_digit), .o_ready(o_ready), .o_ptr(o_ptr), .o_busy(o_busy),
        .o_done(o_done), .o_err(o_err), .o_out0(o_out0), .o_out1(o_out1),
        .o_out2(o_out2), .o_out3(o_out3), .o_out4(o_out4), .o_out5(o_out5)
    );

    always #5 i_clk = ~i_clk;

    assign w_outs = {o_out0, o_out1, o_out2, o_out3, o_out4, o_out5};

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_start();
        i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic send(input logic [3:0] d, input int gap);
        i_valid = 1'b0;
        for (int g = 0; g < gap; g++) step();
        i_valid = 1'b1;
        i_digit = d;
        step();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #12;
        n_total++; if (w_outs !== 24'h000000) $display("FAIL reset_outs: got %h expected 000000", w_outs); else n_pass++;
        n_total++; if ({o_ready, o_busy, o_done, o_err, o_ptr} !== 7'd0) $display("FAIL reset_ctrl: got %b expected 0000000", {o_ready, o_busy, o_done, o_err, o_ptr}); else n_pass++;
        i_rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        int n_ready = 0;
        do_start();
        for (int k = 0; k < 6; k++) begin
            n_total++; if (o_ptr !== 3'(k)) $display("FAIL b2b_ptr%0d: got %0d expected %0d", k, o_ptr, k); else n_pass++;
            if (o_ready === 1'b1) n_ready++;
            i_valid = 1'b1;
            i_digit = 4'(k + 1);
            step();
        end
        i_valid = 1'b0;
        n_total++; if (n_ready !== 6) $display("FAIL b2b_ready_cycles: got %0d expected 6", n_ready); else n_pass++;
        n_total++; if ({o_ready, o_busy, o_done} !== 3'b010) $display("FAIL b2b_commit_state: got %b expected 010", {o_ready, o_busy, o_done}); else n_pass++;
        n_total++; if (w_outs !== 24'h000000) $display("FAIL b2b_outs_stable: got %h expected 000000", w_outs); else n_pass++;
        step();
        n_total++; if (w_outs !== 24'h123456) $display("FAIL b2b_outs: got %h expected 123456", w_outs); else n_pass++;
        n_total++; if ({o_done, o_busy, o_err, o_ptr} !== 6'b100000) $display("FAIL b2b_done: got %b expected 100000", {o_done, o_busy, o_err, o_ptr}); else n_pass++;
        step();
        n_total++; if (o_done !== 1'b0) $display("FAIL b2b_done_pulse: got %b expected 0", o_done); else n_pass++;
    endtask

    task automatic test_gaps_and_hours_limit();
        do_start();
        send(4'd2, 2); send(4'd3, 0); send(4'd5, 1);
        send(4'd9, 3); send(4'd5, 0); send(4'd9, 2);
        step();
        n_total++; if (w_outs !== 24'h235959) $display("FAIL gap_outs: got %h expected 235959", w_outs); else n_pass++;
        n_total++; if (o_done !== 1'b1) $display("FAIL gap_done: got %b expected 1", o_done); else n_pass++;
        do_start();
        send(4'd2, 0);
        send(4'd4, 0);
        n_total++; if ({o_err, o_busy, o_ready, o_ptr, o_done} !== 7'b1000000) $display("FAIL hr24_err: got %b expected 1000000", {o_err, o_busy, o_ready, o_ptr, o_done}); else n_pass++;
        step();
        n_total++; if (w_outs !== 24'h235959) $display("FAIL hr24_outs: got %h expected 235959", w_outs); else n_pass++;
        n_total++; if ({o_done, o_err} !== 2'b01) $display("FAIL hr24_sticky: got %b expected 01", {o_done, o_err}); else n_pass++;
    endtask

    task automatic test_bad_code();
        do_start();
        n_total++; if (o_err !== 1'b0) $display("FAIL badc_clear_on_start: got %b expected 0", o_err); else n_pass++;
        send(4'd1, 0); send(4'd2, 0); send(4'd3, 0);
        send(4'hA, 0);
        n_total++; if ({o_err, o_busy, o_ptr} !== 5'b10000) $display("FAIL badc_err: got %b expected 10000", {o_err, o_busy, o_ptr}); else n_pass++;
        step();
        n_total++; if ({o_done, w_outs} !== {1'b0, 24'h235959}) $display("FAIL badc_no_commit: got %h expected 0235959", {o_done, w_outs}); else n_pass++;
        do_start();
        n_total++; if ({o_err, o_ready} !== 2'b01) $display("FAIL badc_restart: got %b expected 01", {o_err, o_ready}); else n_pass++;
    endtask

    task automatic test_restart_priority();
        do_start();
        send(4'd1, 0); send(4'd1, 0); send(4'd1, 0);
        n_total++; if (o_ptr !== 3'd3) $display("FAIL rst_pri_ptr3: got %0d expected 3", o_ptr); else n_pass++;
        i_start = 1'b1; i_valid = 1'b1; i_digit = 4'd7;
        step();
        i_start = 1'b0; i_valid = 1'b0;
        n_total++; if ({o_ptr, o_ready} !== 4'b0001) $display("FAIL rst_pri_drop: got %b expected 0001", {o_ptr, o_ready}); else n_pass++;
        send(4'd0, 0); send(4'd0, 0); send(4'd0, 0);
        send(4'd0, 0); send(4'd0, 0); send(4'd1, 0);
        step();
        n_total++; if ({o_done, w_outs} !== {1'b1, 24'h000001}) $display("FAIL rst_pri_outs: got %h expected 1000001", {o_done, w_outs}); else n_pass++;
    endtask

    task automatic test_async_reset();
        int n_done = 0;
        do_start();
        send(4'd2, 0); send(4'd1, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        n_total++; if (w_outs !== 24'h000000) $display("FAIL arst_outs: got %h expected 000000", w_outs); else n_pass++;
        n_total++; if ({o_ready, o_busy, o_done, o_err, o_ptr} !== 7'd0) $display("FAIL arst_ctrl: got %b expected 0000000", {o_ready, o_busy, o_done, o_err, o_ptr}); else n_pass++;
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b1;
        i_valid = 1'b1; i_digit = 4'd5;
        for (int k = 0; k < 8; k++) begin
            step();
            if (o_done === 1'b1 || o_ready === 1'b1) n_done++;
        end
        i_valid = 1'b0;
        n_total++; if ({n_done, w_outs} !== {32'd0, 24'h000000}) $display("FAIL arst_after: got %0d/%h expected 0/000000", n_done, w_outs); else n_pass++;
    endtask

    task automatic test_idle_and_commit_start();
        int n_acc = 0;
        i_valid = 1'b1; i_digit = 4'd3;
        for (int k = 0; k < 3; k++) begin
            step();
            if (o_ready !== 1'b0 || o_busy !== 1'b0 || o_ptr !== 3'd0) n_acc++;
        end
        n_total++; if (n_acc !== 0) $display("FAIL idle_valid: got %0d bad cycles expected 0", n_acc); else n_pass++;
        do_start();
        for (int k = 0; k < 6; k++) begin
            i_digit = 4'(k + 1);
            step();
        end
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        n_total++; if ({o_done, o_busy, o_ptr, w_outs} !== {2'b10, 3'd0, 24'h123456}) $display("FAIL cmt_start: got %h expected %h", {o_done, o_busy, o_ptr, w_outs}, {2'b10, 3'd0, 24'h123456}); else n_pass++;
        step();
        n_total++; if ({o_done, o_busy, o_ready} !== 3'b000) $display("FAIL cmt_no_restart: got %b expected 000", {o_done, o_busy, o_ready}); else n_pass++;
        i_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps_and_hours_limit();
        test_bad_code();
        test_restart_priority();
        test_async_reset();
        test_idle_and_commit_start();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
